// File: rtl/pst_mon_pkg.sv
// Shared definitions for the PST convergence monitor: FSM encoding, parameter
// defaults and a saturating counter helper.
package pst_mon_pkg;

  typedef enum logic [1:0] {
    S_INIT     = 2'd0,
    S_LOCKED   = 2'd1,
    S_SETTLING = 2'd2
  } state_t;

  localparam int HOLD_DEF    = 2;
  localparam int ERR_TOL_DEF = 3;
  localparam int MIN_LAT_DEF = 2;
  localparam int TIMEOUT_DEF = 15;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/pst_converge_monitor_if.sv
// Brain-side sample stream and monitor result bundle.
interface pst_converge_monitor_if;
  logic       cyc_start;
  logic [2:0] winner;
  logic [7:0] pred_err;
  logic       switch_pulse;
  logic       done_pulse;
  logic [7:0] conv_cycles;
  logic       conv_timeout;
  logic [7:0] prev_conv_cycles;
  logic       faster;
  logic [7:0] switch_count;
  logic [7:0] abort_count;
  logic [1:0] state;

  modport master (
    output cyc_start, winner, pred_err,
    input  switch_pulse, done_pulse, conv_cycles, conv_timeout,
           prev_conv_cycles, faster, switch_count, abort_count, state
  );

  modport slave (
    input  cyc_start, winner, pred_err,
    output switch_pulse, done_pulse, conv_cycles, conv_timeout,
           prev_conv_cycles, faster, switch_count, abort_count, state
  );
endinterface

// File: rtl/pst_winner_debounce.sv
// Winner debouncer: a new winner must persist HOLD consecutive samples before
// it replaces the stable winner; fire flags the completing sample.
module pst_winner_debounce
  import pst_mon_pkg::*;
#(
  parameter int HOLD = HOLD_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sample,
  input  logic       load,
  input  logic [2:0] winner,
  output logic       fire
);
  localparam logic [7:0] HOLD_L = 8'(HOLD);

  logic [2:0] stable_w, cand;
  logic [7:0] cand_cnt, cnt_nxt;

  always_comb begin
    cnt_nxt = 8'd0;
    if (winner == stable_w)  cnt_nxt = 8'd0;
    else if (winner == cand) cnt_nxt = cand_cnt + 8'd1;
    else                     cnt_nxt = 8'd1;
    fire = sample && (winner != stable_w) && (cnt_nxt >= HOLD_L);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stable_w <= 3'd0;
      cand     <= 3'd0;
      cand_cnt <= 8'd0;
    end else if (load) begin
      stable_w <= winner;
      cand_cnt <= 8'd0;
    end else if (sample) begin
      // every completing path has the current winner as candidate
      if (fire) begin
        stable_w <= winner;
        cand     <= winner;
        cand_cnt <= 8'd0;
      end else begin
        if (winner != stable_w && winner != cand) cand <= winner;
        cand_cnt <= cnt_nxt;
      end
    end
  end
endmodule

// File: rtl/pst_converge_monitor.sv
// Measures how many gamma samples the brain needs to settle (low prediction
// error) after each debounced attention switch, and keeps switch/abort stats.
module pst_converge_monitor
  import pst_mon_pkg::*;
#(
  parameter int HOLD    = HOLD_DEF,
  parameter int ERR_TOL = ERR_TOL_DEF,
  parameter int MIN_LAT = MIN_LAT_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input logic                   clk,
  input logic                   rst,
  pst_converge_monitor_if.slave bus
);
  localparam logic [7:0] HOLD_L = 8'(HOLD);
  localparam logic [7:0] TOL_L  = 8'(ERR_TOL);
  localparam logic [7:0] MIN_L  = 8'(MIN_LAT);
  localparam logic [7:0] TO_L   = 8'(TIMEOUT);
  localparam logic [7:0] LAT0   = (HOLD_L > TO_L) ? TO_L : HOLD_L;

  state_t     st;
  logic [7:0] lat, lat_inc, done_val;
  logic       done_seen, fire, sample, load, conv_ok, to_hit;

  assign load   = bus.cyc_start && (st == S_INIT);
  assign sample = bus.cyc_start && (st == S_LOCKED || st == S_SETTLING);
  assign bus.state = st;

  pst_winner_debounce #(.HOLD(HOLD)) u_deb (
    .clk    (clk),
    .rst    (rst),
    .sample (sample),
    .load   (load),
    .winner (bus.winner),
    .fire   (fire)
  );

  // convergence beats timeout when both land on the same sample
  always_comb begin
    lat_inc  = (lat >= TO_L) ? TO_L : lat + 8'd1;
    conv_ok  = (lat_inc >= MIN_L) && (bus.pred_err <= TOL_L);
    to_hit   = (lat_inc >= TO_L);
    done_val = conv_ok ? lat_inc : TO_L;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st                   <= S_INIT;
      lat                  <= 8'd0;
      done_seen            <= 1'b0;
      bus.switch_pulse     <= 1'b0;
      bus.done_pulse       <= 1'b0;
      bus.conv_cycles      <= 8'd0;
      bus.conv_timeout     <= 1'b0;
      bus.prev_conv_cycles <= 8'd0;
      bus.faster           <= 1'b0;
      bus.switch_count     <= 8'd0;
      bus.abort_count      <= 8'd0;
    end else begin
      bus.switch_pulse <= 1'b0;
      bus.done_pulse   <= 1'b0;
      case (st)
        S_INIT: if (bus.cyc_start) st <= S_LOCKED;
        S_LOCKED: if (sample && fire) begin
          bus.switch_pulse <= 1'b1;
          bus.switch_count <= sat_inc(bus.switch_count);
          lat              <= LAT0;
          st               <= S_SETTLING;
        end
        S_SETTLING: if (sample) begin
          if (fire) begin
            // a fresh switch restarts the measurement, dropping the open one
            bus.switch_pulse <= 1'b1;
            bus.switch_count <= sat_inc(bus.switch_count);
            bus.abort_count  <= sat_inc(bus.abort_count);
            lat              <= LAT0;
          end else if (conv_ok || to_hit) begin
            bus.done_pulse       <= 1'b1;
            bus.conv_cycles      <= done_val;
            bus.conv_timeout     <= !conv_ok;
            bus.prev_conv_cycles <= bus.conv_cycles;
            bus.faster           <= done_seen && (done_val < bus.conv_cycles);
            done_seen            <= 1'b1;
            lat                  <= lat_inc;
            st                   <= S_LOCKED;
          end else begin
            lat <= lat_inc;
          end
        end
        default: st <= S_INIT;
      endcase
    end
  end
endmodule
